// File: rtl/i2cmb_env_pkg.sv
// Shared register map, command codes, status layouts and error bit positions
// for the i2cmb environment and its protocol monitor.
package i2cmb_env_pkg;

  localparam int NUM_ERR = 7;

  typedef enum logic [1:0] {
    REG_CSR  = 2'd0,
    REG_DPR  = 2'd1,
    REG_CMDR = 2'd2,
    REG_FSMR = 2'd3
  } reg_addr_e;

  typedef enum logic [2:0] {
    CMD_WAIT     = 3'b000,
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110,
    CMD_INVALID  = 3'b111
  } i2c_cmd_e;

  typedef struct packed {
    logic       don;
    logic       nak;
    logic       al;
    logic       err;
    logic       rsvd;
    logic [2:0] cmd;
  } cmdr_reg_t;

  typedef struct packed {
    logic       e;
    logic       ie;
    logic       bb;
    logic       bc;
    logic [3:0] bus_id;
  } csr_reg_t;

  typedef enum logic [2:0] {
    ERR_TIMEOUT     = 3'd0,
    ERR_BAD_CMD     = 3'd1,
    ERR_OVERLAP     = 3'd2,
    ERR_IRQ_NO_IE   = 3'd3,
    ERR_IRQ_STUCK   = 3'd4,
    ERR_WRONG_BUS   = 3'd5,
    ERR_BB_MISMATCH = 3'd6
  } err_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mon_state_e;

  function automatic logic [2:0] err_popcount(input logic [NUM_ERR-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_ERR; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/i2c_bus_cond_detect.sv
// START/STOP condition detector for a single I2C bus; busy tracks START..STOP.
module i2c_bus_cond_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl,
  input  logic sda,
  output logic start,
  output logic stop,
  output logic busy
);

  logic scl_q;
  logic sda_q;

  assign start = scl_q & scl & sda_q & ~sda;
  assign stop  = scl_q & scl & ~sda_q & sda;

  // Previous-line registers reset high so an idle bus never looks like an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      busy  <= 1'b0;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
      if (start)
        busy <= 1'b1;
      else if (stop)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/i2cmb_protocol_monitor.sv
// Passive i2cmb protocol monitor: shadows CSR/CMDR, tracks command lifetime and
// flags rule violations. Define I2CMB_MON_BB_CHECK_EN to enable the CSR bb check.
module i2cmb_protocol_monitor
  import i2cmb_env_pkg::*;
#(
  parameter int NUM_I2C_BUSSES     = 1,
  parameter int WB_ADDR_WIDTH      = 2,
  parameter int WB_DATA_WIDTH      = 8,
  parameter int CMD_TIMEOUT_CYCLES = 4096,
  parameter int IRQ_CLR_LATENCY    = 2,
  parameter int ERR_CNT_WIDTH      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cyc_o,
  input  logic                      stb_o,
  input  logic                      we_o,
  input  logic                      ack_i,
  input  logic [WB_ADDR_WIDTH-1:0]  adr_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      irq_i,
  input  logic [NUM_I2C_BUSSES-1:0] scl_i,
  input  logic [NUM_I2C_BUSSES-1:0] sda_i,
  output logic [NUM_ERR-1:0]        err_pulse_o,
  output logic [NUM_ERR-1:0]        err_sticky_o,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
  output logic                      cmd_pending_o,
  output logic [NUM_I2C_BUSSES-1:0] bus_busy_o,
  output logic [3:0]                sel_bus_o
);

  localparam int TMR_W = (CMD_TIMEOUT_CYCLES > 0) ? $clog2(CMD_TIMEOUT_CYCLES + 1) : 1;
  localparam int LAT_W = (IRQ_CLR_LATENCY > 0) ? $clog2(IRQ_CLR_LATENCY + 1) : 1;
  localparam bit TIMEOUT_EN = (CMD_TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(CMD_TIMEOUT_CYCLES);
  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(IRQ_CLR_LATENCY);
  localparam logic [4:0] NUM_B = 5'(NUM_I2C_BUSSES);

  logic wr_hs, rd_hs;
  logic csr_wr, csr_rd, dpr_wr, cmdr_wr, cmdr_rd;
  reg_addr_e addr;

  assign wr_hs   = cyc_o & stb_o & we_o & ack_i;
  assign rd_hs   = cyc_o & stb_o & ~we_o & ack_i;
  assign addr    = reg_addr_e'(adr_o[1:0]);
  assign csr_wr  = wr_hs && (addr == REG_CSR);
  assign csr_rd  = rd_hs && (addr == REG_CSR);
  assign dpr_wr  = wr_hs && (addr == REG_DPR);
  assign cmdr_wr = wr_hs && (addr == REG_CMDR);
  assign cmdr_rd = rd_hs && (addr == REG_CMDR);

  mon_state_e        state_q, state_d;
  csr_reg_t          csr_q;
  cmdr_reg_t         cmdr_q, cmdr_d, rd_stat;
  logic [3:0]        dpr_q;
  logic [3:0]        bus_id_q, bus_id_d;
  logic [3:0]        sel_bus_q, sel_bus_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              irq_q, irq_rise;
  logic              launch;
  logic              err_timeout, err_bad_cmd, err_overlap;
  logic              err_no_ie, err_stuck, err_wrong_bus, err_bb;
  logic [NUM_ERR-1:0] err_now;

  assign rd_stat  = cmdr_reg_t'(dat_i[7:0]);
  assign irq_rise = irq_i & ~irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      csr_q     <= '0;
      cmdr_q    <= '0;
      dpr_q     <= '0;
      bus_id_q  <= '0;
      sel_bus_q <= '0;
      timer_q   <= '0;
      irq_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmdr_q    <= cmdr_d;
      bus_id_q  <= bus_id_d;
      sel_bus_q <= sel_bus_d;
      timer_q   <= timer_d;
      irq_q     <= irq_i;
      if (csr_wr) csr_q <= csr_reg_t'(dat_o[7:0]);
      if (dpr_wr) dpr_q <= dat_o[3:0];
    end
  end

  // A CMDR write from IDLE/DONE starts a command; from BUSY it is an overlap
  // that relatches and restarts the timer.
  always_comb begin
    state_d     = state_q;
    cmdr_d      = cmdr_q;
    bus_id_d    = bus_id_q;
    sel_bus_d   = sel_bus_q;
    timer_d     = timer_q;
    launch      = 1'b0;
    err_timeout = 1'b0;
    err_bad_cmd = 1'b0;
    err_overlap = 1'b0;
    unique case (state_q)
      IDLE: launch = cmdr_wr;
      BUSY: begin
        timer_d = timer_q + 1'b1;
        if (csr_wr && !dat_o[7]) begin
          state_d = IDLE;
        end else if (cmdr_wr) begin
          launch      = 1'b1;
          err_overlap = 1'b1;
        end else if (irq_rise || (cmdr_rd && (dat_i[7:4] != 4'd0))) begin
          state_d = DONE;
        end else if (TIMEOUT_EN && (cmdr_q.cmd != CMD_WAIT) && (timer_q == TMR_LIMIT)) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      DONE: begin
        if (cmdr_rd) begin
          state_d = IDLE;
          if ((cmdr_q.cmd == CMD_INVALID) && rd_stat.don) err_bad_cmd = 1'b1;
          // Only in-range bus ids are accepted as the new selected bus.
          if (cmdr_q.cmd == CMD_SET_BUS) begin
            if ({1'b0, bus_id_q} < NUM_B) begin
              if (rd_stat.don) sel_bus_d = bus_id_q;
            end else if (!rd_stat.err) begin
              err_bad_cmd = 1'b1;
            end
          end
        end else begin
          launch = cmdr_wr;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = BUSY;
      cmdr_d  = cmdr_reg_t'(dat_o[7:0]);
      timer_d = '0;
      if (dat_o[2:0] == CMD_SET_BUS) bus_id_d = dpr_q;
    end
  end

  logic             stuck_armed_q;
  logic [LAT_W-1:0] stuck_cnt_q;

  assign err_no_ie = irq_i & ~csr_q.ie;
  assign err_stuck = stuck_armed_q && irq_i && (stuck_cnt_q == LAT_LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stuck_armed_q <= 1'b0;
      stuck_cnt_q   <= '0;
    end else if (cmdr_rd) begin
      stuck_armed_q <= 1'b1;
      stuck_cnt_q   <= '0;
    end else if (stuck_armed_q) begin
      if (!irq_i || err_stuck)
        stuck_armed_q <= 1'b0;
      else
        stuck_cnt_q <= stuck_cnt_q + 1'b1;
    end
  end

  logic [NUM_I2C_BUSSES-1:0] start_p, stop_p;

  for (genvar g = 0; g < NUM_I2C_BUSSES; g++) begin : g_bus
    i2c_bus_cond_detect u_det (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .scl   (scl_i[g]),
      .sda   (sda_i[g]),
      .start (start_p[g]),
      .stop  (stop_p[g]),
      .busy  (bus_busy_o[g])
    );
  end

  always_comb begin
    err_wrong_bus = 1'b0;
    for (int b = 0; b < NUM_I2C_BUSSES; b++)
      if (start_p[b] && (!csr_q.e || (sel_bus_q != 4'(b)))) err_wrong_bus = 1'b1;
  end

`ifdef I2CMB_MON_BB_CHECK_EN
  logic [15:0] busy_pad;
  assign busy_pad = 16'(bus_busy_o);
  assign err_bb   = csr_rd && (dat_i[5] != busy_pad[sel_bus_q]);
`else
  assign err_bb = 1'b0;
`endif

  always_comb begin
    err_now                  = '0;
    err_now[ERR_TIMEOUT]     = err_timeout;
    err_now[ERR_BAD_CMD]     = err_bad_cmd;
    err_now[ERR_OVERLAP]     = err_overlap;
    err_now[ERR_IRQ_NO_IE]   = err_no_ie;
    err_now[ERR_IRQ_STUCK]   = err_stuck;
    err_now[ERR_WRONG_BUS]   = err_wrong_bus;
    err_now[ERR_BB_MISMATCH] = err_bb;
  end

  // Extra headroom bits let the add detect overflow before saturating.
  logic [ERR_CNT_WIDTH+2:0] cnt_sum;
  assign cnt_sum = {3'b000, err_cnt_o} + (ERR_CNT_WIDTH+3)'(err_popcount(err_now));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pulse_o  <= '0;
      err_sticky_o <= '0;
      err_cnt_o    <= '0;
    end else begin
      err_pulse_o  <= err_now;
      err_sticky_o <= err_sticky_o | err_now;
      err_cnt_o    <= (|cnt_sum[ERR_CNT_WIDTH+2:ERR_CNT_WIDTH]) ? '1 : cnt_sum[ERR_CNT_WIDTH-1:0];
    end
  end

  assign cmd_pending_o = (state_q != IDLE);
  assign sel_bus_o     = sel_bus_q;

  logic unused_sink;
  assign unused_sink = ^{adr_o, dat_o, dat_i, csr_rd, stop_p, csr_q, cmdr_q, rd_stat};

endmodule
